reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//  Shares one DATA_W-bit register among N_REQ writers.
//  Round-robin arbitration, one write per transaction, req/ack handshake per requester.
//  A clear input restores the register to RST_VAL.
//  Sits in front of shared config/status storage that several blocks may update.
// PARAMETERS
//  N_REQ   4            number of requesters (>=2)
//  DATA_W  8            register / write-data width
//  RST_VAL {DATA_W{0}}  value loaded on reset and on clear
// PORTS
//  clk_i     in   1               clock, all logic on posedge
//  rst_i     in   1               synchronous reset, active-high
//  req_i     in   N_REQ           per-requester write request, level, held until ack
//  data_i    in   N_REQ*DATA_W    write data, requester k in [k*DATA_W +: DATA_W]
//  clr_i     in   1               clear register to RST_VAL, highest priority
//  grant_o   out  N_REQ           one-hot, high for the whole WRITE state
//  ack_o     out  N_REQ           one-hot 1-cycle pulse, write committed
//  update_o  out  1               1-cycle pulse, data_o changed by a write or clear
//  owner_o   out  $clog2(N_REQ)   index of the last requester whose write committed
//  busy_o    out  1               state != IDLE
//  data_o    out  DATA_W          current register value
// BEHAVIOUR
//  Reset (rst_i=1 at posedge), taking effect from any state:
//   - state=IDLE, rr_ptr=0, data_o=RST_VAL, owner_o=0
//   - grant_o, ack_o, update_o and busy_o all 0
//   - a transaction in flight is dropped with no ack.
//  FSM states: IDLE -> WRITE -> ACK -> IDLE.
//  IDLE:
//   - clr_i=1: data_o<=RST_VAL, update_o pulses next cycle, stay IDLE. Requests are ignored this cycle.
//   - else, if any req_i: winner = first set bit searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//     grant_o<=onehot(winner), go WRITE.
//  WRITE (cycle N+1 when req seen in cycle N):
//   - clr_i=1: data_o<=RST_VAL, update_o pulses, no ack, rr_ptr unchanged, go IDLE.
//   - else if req_i[winner]=0 (requester withdrew): abort. No write, no ack, rr_ptr unchanged, go IDLE.
//   - else: data_o<=data_i[winner], owner_o<=winner, rr_ptr<=(winner+1) mod N_REQ, go ACK.
//  ACK (cycle N+2):
//   - ack_o=onehot(winner) and update_o=1 for exactly this cycle; grant_o=0.
//   - Always go IDLE.
//   - clr_i in ACK is applied: data_o<=RST_VAL, one more update_o pulse in cycle N+3.
//  Latency and throughput:
//   - req to data_o visible and ack: 2 cycles.
//   - max 1 write per 3 cycles.
//  Handshake rules:
//   - Requester holds req_i and its data slice stable until ack_o seen.
//   - Requester deasserts req_i on the edge after ack; otherwise a new write is requested.
//  data_i is sampled only at the WRITE edge; changes in other cycles have no effect.
//  grant_o / ack_o: at most one bit set, never both set in the same cycle.
// TESTING
//  1 Reset: rst_i high 2 cycles mid-WRITE -> data_o=RST_VAL, grant_o=ack_o=0, busy_o=0, no ack.
//  2 Single request (N_REQ=4, DATA_W=8): req_i=0100, data 0xA5 at cycle N
//    -> grant_o=0100 @N+1; data_o=0xA5, ack_o=0100, update_o=1, owner_o=2 @N+2; busy_o=1 @N+1..N+2.
//  3 Fairness: req_i=1111 held, each requester drops and re-raises around its ack
//    -> grant order 0,1,2,3,0; one ack every 3 cycles.
//  4 Withdraw: req 3 granted, req_i[3] dropped in WRITE
//    -> no write, no ack, data_o unchanged; next grant still starts search at 3.
//  5 Clear race: req1 with data 0x3C, clr_i=1 in WRITE
//    -> data_o=RST_VAL, no ack; req1 re-arbitrated, data_o=0x3C after 3 more cycles.
//  6 Wrap: rr_ptr=3 after ack of 2, req_i=0011 -> grant_o=0001, then 0010.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// Write-port bundle for reg_write_arbiter: per-requester req/data in,
// grant/ack handshake and the shared register state out.
interface reg_write_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_i;
  logic [N_REQ*DATA_W-1:0] data_i;
  logic                    clr_i;
  logic [N_REQ-1:0]        grant_o;
  logic [N_REQ-1:0]        ack_o;
  logic                    update_o;
  logic [IDX_W-1:0]        owner_o;
  logic                    busy_o;
  logic [DATA_W-1:0]       data_o;

  // Writers and the clear source drive requests; they observe the register state.
  modport master (
    output req_i, data_i, clr_i,
    input  grant_o, ack_o, update_o, owner_o, busy_o, data_o
  );

  // The arbiter consumes requests and owns the register.
  modport slave (
    input  req_i, data_i, clr_i,
    output grant_o, ack_o, update_o, owner_o, busy_o, data_o
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Shared register with round-robin write arbitration among N_REQ requesters.
// One write per IDLE -> WRITE -> ACK transaction; clear has top priority.
module reg_write_arbiter #(
  parameter int unsigned      N_REQ   = 4,
  parameter int unsigned      DATA_W  = 8,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input logic                clk_i,
  input logic                rst_i,
  reg_write_arbiter_if.slave bus
);

  localparam int unsigned      IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_e;

  state_e            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  winner;
  logic [N_REQ-1:0]  grant_q;
  logic [N_REQ-1:0]  ack_q;
  logic              update_q;
  logic [IDX_W-1:0]  owner_q;
  logic              busy_q;
  logic [DATA_W-1:0] data_q;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  rr_next;
  logic [DATA_W-1:0] slot [N_REQ];

  // Unpack the flat write-data bus into one slot per requester.
  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      slot[k] = bus.data_i[k*DATA_W +: DATA_W];
    end
  end

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((32'(rr_ptr) + i) % N_REQ);
      if (!pick_valid && bus.req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign rr_next = (winner == LAST_IDX) ? '0 : winner + 1'b1;

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      winner   <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      update_q <= 1'b0;
      owner_q  <= '0;
      busy_q   <= 1'b0;
      data_q   <= RST_VAL;
    end else begin
      ack_q    <= '0;
      update_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clr_i) begin
            data_q   <= RST_VAL;
            update_q <= 1'b1;
          end else if (pick_valid) begin
            winner  <= pick_idx;
            grant_q <= ONE_HOT0 << pick_idx;
            busy_q  <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          grant_q <= '0;
          if (bus.clr_i) begin
            data_q   <= RST_VAL;
            update_q <= 1'b1;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else if (!bus.req_i[winner]) begin
            // Requester withdrew: drop the transaction, keep the pointer.
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            data_q   <= slot[winner];
            owner_q  <= winner;
            rr_ptr   <= rr_next;
            ack_q    <= ONE_HOT0 << winner;
            update_q <= 1'b1;
            state    <= ACK;
          end
        end
        ACK: begin
          busy_q <= 1'b0;
          state  <= IDLE;
          if (bus.clr_i) begin
            data_q   <= RST_VAL;
            update_q <= 1'b1;
          end
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant_o  = grant_q;
  assign bus.ack_o    = ack_q;
  assign bus.update_o = update_q;
  assign bus.owner_o  = owner_q;
  assign bus.busy_o   = busy_q;
  assign bus.data_o   = data_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (N_REQ=4, DATA_W=8, RST_VAL=0).
module tb_reg_write_arbiter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  reg_write_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();

  reg_write_arbiter #(.N_REQ(4), .DATA_W(8), .RST_VAL(8'h00)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [7:0] v);
    bus.data_i[k*8 +: 8] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_tests++; if (bus.data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", bus.data_o); end
    n_tests++; if (bus.grant_o !== 4'b0000 || bus.ack_o !== 4'b0000) begin n_fail++; $display("FAIL reset_grant_ack got %b/%b want 0000/0000", bus.grant_o, bus.ack_o); end
    n_tests++; if (bus.busy_o !== 1'b0 || bus.update_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy_update got %b/%b want 0/0", bus.busy_o, bus.update_o); end
    n_tests++; if (bus.owner_o !== 2'd0) begin n_fail++; $display("FAIL reset_owner got %0d want 0", bus.owner_o); end
  endtask

  task automatic test_single();
    bus.req_i = 4'b0100;
    set_data(2, 8'hA5);
    tick();
    n_tests++; if (bus.grant_o !== 4'b0100 || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL single_grant got %b busy %b want 0100 busy 1", bus.grant_o, bus.busy_o); end
    n_tests++; if (bus.ack_o !== 4'b0000 || bus.data_o !== 8'h00) begin n_fail++; $display("FAIL single_early got ack %b data %h want 0000 00", bus.ack_o, bus.data_o); end
    tick();
    n_tests++; if (bus.data_o !== 8'hA5 || bus.owner_o !== 2'd2) begin n_fail++; $display("FAIL single_write got %h owner %0d want a5 owner 2", bus.data_o, bus.owner_o); end
    n_tests++; if (bus.ack_o !== 4'b0100 || bus.update_o !== 1'b1 || bus.grant_o !== 4'b0000 || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL single_ack got ack %b upd %b grant %b busy %b want 0100 1 0000 1", bus.ack_o, bus.update_o, bus.grant_o, bus.busy_o); end
    bus.req_i = 4'b0000;
    tick();
    n_tests++; if (bus.ack_o !== 4'b0000 || bus.update_o !== 1'b0 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL single_done got ack %b upd %b busy %b want 0000 0 0", bus.ack_o, bus.update_o, bus.busy_o); end
  endtask

  // rr_ptr is 3 here, so requesters 0 and 1 are served 0 then 1.
  task automatic test_wrap();
    bus.req_i = 4'b0011;
    set_data(0, 8'h01);
    set_data(1, 8'h02);
    tick();
    n_tests++; if (bus.grant_o !== 4'b0001) begin n_fail++; $display("FAIL wrap_grant0 got %b want 0001", bus.grant_o); end
    tick();
    n_tests++; if (bus.ack_o !== 4'b0001 || bus.data_o !== 8'h01 || bus.owner_o !== 2'd0) begin n_fail++; $display("FAIL wrap_ack0 got %b %h %0d want 0001 01 0", bus.ack_o, bus.data_o, bus.owner_o); end
    bus.req_i = 4'b0010;
    tick();
    n_tests++; if (bus.busy_o !== 1'b0 || bus.grant_o !== 4'b0000) begin n_fail++; $display("FAIL wrap_idle got busy %b grant %b want 0 0000", bus.busy_o, bus.grant_o); end
    tick();
    n_tests++; if (bus.grant_o !== 4'b0010) begin n_fail++; $display("FAIL wrap_grant1 got %b want 0010", bus.grant_o); end
    tick();
    n_tests++; if (bus.ack_o !== 4'b0010 || bus.data_o !== 8'h02 || bus.owner_o !== 2'd1) begin n_fail++; $display("FAIL wrap_ack1 got %b %h %0d want 0010 02 1", bus.ack_o, bus.data_o, bus.owner_o); end
    bus.req_i = 4'b0000;
    tick();
  endtask

  // rr_ptr is 2: requester 3 withdraws, then 0/1/3 compete and 3 must still win.
  task automatic test_withdraw();
    bus.req_i = 4'b1000;
    set_data(3, 8'h77);
    tick();
    n_tests++; if (bus.grant_o !== 4'b1000) begin n_fail++; $display("FAIL withdraw_grant got %b want 1000", bus.grant_o); end
    bus.req_i = 4'b0000;
    tick();
    n_tests++; if (bus.ack_o !== 4'b0000 || bus.update_o !== 1'b0 || bus.grant_o !== 4'b0000 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL withdraw_abort got ack %b upd %b grant %b busy %b want 0000 0 0000 0", bus.ack_o, bus.update_o, bus.grant_o, bus.busy_o); end
    n_tests++; if (bus.data_o !== 8'h02 || bus.owner_o !== 2'd1) begin n_fail++; $display("FAIL withdraw_keep got %h owner %0d want 02 owner 1", bus.data_o, bus.owner_o); end
    tick();
    n_tests++; if (bus.ack_o !== 4'b0000 || bus.data_o !== 8'h02) begin n_fail++; $display("FAIL withdraw_late got ack %b data %h want 0000 02", bus.ack_o, bus.data_o); end
    bus.req_i = 4'b1011;
    set_data(0, 8'h70);
    set_data(1, 8'h71);
    set_data(3, 8'h78);
    tick();
    n_tests++; if (bus.grant_o !== 4'b1000) begin n_fail++; $display("FAIL withdraw_rearb got %b want 1000", bus.grant_o); end
    tick();
    n_tests++; if (bus.ack_o !== 4'b1000 || bus.data_o !== 8'h78 || bus.owner_o !== 2'd3) begin n_fail++; $display("FAIL withdraw_ack got %b %h %0d want 1000 78 3", bus.ack_o, bus.data_o, bus.owner_o); end
    bus.req_i = 4'b0000;
    tick();
  endtask

  // All four held; each drops req for one cycle right after its ack.
  task automatic test_fairness();
    logic [3:0] exp_oh;
    for (int k = 0; k < 4; k++) set_data(k, 8'(8'h10 + k));
    bus.req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      int w;
      w = i % 4;
      exp_oh = 4'b0001 << w;
      tick();
      n_tests++; if (bus.grant_o !== exp_oh || bus.ack_o !== 4'b0000) begin n_fail++; $display("FAIL fair_grant%0d got %b ack %b want %b ack 0000", i, bus.grant_o, bus.ack_o, exp_oh); end
      tick();
      n_tests++; if (bus.ack_o !== exp_oh || bus.grant_o !== 4'b0000 || bus.data_o !== 8'(8'h10 + w) || bus.owner_o !== 2'(w)) begin n_fail++; $display("FAIL fair_ack%0d got ack %b grant %b data %h owner %0d want %b 0000 %h %0d", i, bus.ack_o, bus.grant_o, bus.data_o, bus.owner_o, exp_oh, 8'(8'h10 + w), w); end
      bus.req_i[w] = 1'b0;
      tick();
      n_tests++; if (bus.ack_o !== 4'b0000 || bus.grant_o !== 4'b0000 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL fair_gap%0d got ack %b grant %b busy %b want 0000 0000 0", i, bus.ack_o, bus.grant_o, bus.busy_o); end
      if (i == 4) bus.req_i = 4'b0000;
      else        bus.req_i[w] = 1'b1;
    end
    tick();
  endtask

  // rr_ptr is 1: clear during WRITE kills the write; requester 1 is served next.
  task automatic test_clear_race();
    bus.req_i = 4'b0010;
    set_data(1, 8'h3C);
    tick();
    n_tests++; if (bus.grant_o !== 4'b0010) begin n_fail++; $display("FAIL clr_grant got %b want 0010", bus.grant_o); end
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
    n_tests++; if (bus.data_o !== 8'h00 || bus.update_o !== 1'b1) begin n_fail++; $display("FAIL clr_write got data %h upd %b want 00 1", bus.data_o, bus.update_o); end
    n_tests++; if (bus.ack_o !== 4'b0000 || bus.grant_o !== 4'b0000 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL clr_noack got ack %b grant %b busy %b want 0000 0000 0", bus.ack_o, bus.grant_o, bus.busy_o); end
    tick();
    n_tests++; if (bus.grant_o !== 4'b0010 || bus.update_o !== 1'b0) begin n_fail++; $display("FAIL clr_regrant got %b upd %b want 0010 0", bus.grant_o, bus.update_o); end
    tick();
    n_tests++; if (bus.ack_o !== 4'b0010 || bus.data_o !== 8'h3C) begin n_fail++; $display("FAIL clr_rewrite got ack %b data %h want 0010 3c", bus.ack_o, bus.data_o); end
    bus.req_i = 4'b0000;
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
    n_tests++; if (bus.data_o !== 8'h00 || bus.update_o !== 1'b1 || bus.ack_o !== 4'b0000) begin n_fail++; $display("FAIL clr_in_ack got data %h upd %b ack %b want 00 1 0000", bus.data_o, bus.update_o, bus.ack_o); end
    tick();
    n_tests++; if (bus.update_o !== 1'b0) begin n_fail++; $display("FAIL clr_pulse got upd %b want 0", bus.update_o); end
  endtask

  task automatic test_clear_idle();
    bus.clr_i = 1'b1;
    bus.req_i = 4'b0001;
    tick();
    bus.clr_i = 1'b0;
    bus.req_i = 4'b0000;
    n_tests++; if (bus.update_o !== 1'b1 || bus.grant_o !== 4'b0000 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL clr_idle got upd %b grant %b busy %b want 1 0000 0", bus.update_o, bus.grant_o, bus.busy_o); end
    tick();
  endtask

  // rr_ptr is 2 going in; reset must drop the write and return the pointer to 0.
  task automatic test_reset_mid_write();
    bus.req_i = 4'b0100;
    set_data(2, 8'h99);
    tick();
    n_tests++; if (bus.grant_o !== 4'b0100) begin n_fail++; $display("FAIL rstw_grant got %b want 0100", bus.grant_o); end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++; if (bus.grant_o !== 4'b0000 || bus.ack_o !== 4'b0000 || bus.busy_o !== 1'b0 || bus.data_o !== 8'h00 || bus.owner_o !== 2'd0) begin n_fail++; $display("FAIL rstw_hold%0d got grant %b ack %b busy %b data %h owner %0d want 0000 0000 0 00 0", c, bus.grant_o, bus.ack_o, bus.busy_o, bus.data_o, bus.owner_o); end
    end
    rst = 1'b0;
    bus.req_i = 4'b1001;
    set_data(0, 8'h21);
    set_data(3, 8'h24);
    tick();
    n_tests++; if (bus.grant_o !== 4'b0001 || bus.ack_o !== 4'b0000) begin n_fail++; $display("FAIL rstw_ptr got grant %b ack %b want 0001 0000", bus.grant_o, bus.ack_o); end
    tick();
    n_tests++; if (bus.ack_o !== 4'b0001 || bus.data_o !== 8'h21) begin n_fail++; $display("FAIL rstw_ack got %b %h want 0001 21", bus.ack_o, bus.data_o); end
    bus.req_i = 4'b0000;
    tick();
  endtask

  // rr_ptr is 1; data changes outside the WRITE edge must not reach data_o.
  task automatic test_back_to_back();
    bus.req_i = 4'b0100;
    set_data(2, 8'h55);
    tick();
    set_data(1, 8'hFF);
    tick();
    n_tests++; if (bus.ack_o !== 4'b0100 || bus.data_o !== 8'h55 || bus.owner_o !== 2'd2) begin n_fail++; $display("FAIL sample_ack got %b %h %0d want 0100 55 2", bus.ack_o, bus.data_o, bus.owner_o); end
    bus.req_i = 4'b0000;
    set_data(2, 8'hEE);
    tick();
    tick();
    n_tests++; if (bus.data_o !== 8'h55 || bus.update_o !== 1'b0) begin n_fail++; $display("FAIL sample_hold got %h upd %b want 55 0", bus.data_o, bus.update_o); end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.req_i = '0;
    bus.data_i = '0;
    bus.clr_i = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_withdraw();
    test_fairness();
    test_clear_race();
    test_clear_idle();
    test_reset_mid_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
